// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer and its matching SIPO deserializer.
// The state encodings must stay identical on both sides of the serial link.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_t;

  // Width of a bit counter that must reach width-1 without wrapping.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer.
// Clears on a word accept and advances one position per shifted bit.
module piso_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      inc,
  output logic [cnt_w(WIDTH)-1:0]  count,
  output logic                      at_last
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  // The caller only raises inc below LAST_COUNT, so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign at_last = (count == LAST_COUNT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with valid/ready load and framing flags.
// Words follow each other without a gap when the next one is ready on the final bit.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             en,
  output logic             out,
  output logic             out_valid,
  output logic             last
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  shift_state_t     state_reg;
  shift_state_t     state_next;
  logic [WIDTH-1:0] sr_reg;
  logic [CW-1:0]    count;
  logic             at_last;
  logic             accept;
  logic             advance;
  logic             head;

  // Ready is the one output allowed to see en: the final bit frees the register.
  always_comb begin
    load_ready = 1'b0;
    if (!rst) begin
      if (state_reg == ST_IDLE) begin
        load_ready = 1'b1;
      end else if (at_last && en) begin
        load_ready = 1'b1;
      end
    end
  end

  assign accept  = load_valid && load_ready;
  assign advance = (state_reg == ST_SHIFT) && en && !at_last;

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .inc     (advance),
    .count   (count),
    .at_last (at_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (en && at_last) state_next = accept ? ST_SHIFT : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg <= '0;
    end else if (accept) begin
      sr_reg <= in;
    end else if (advance) begin
      if (MSB_FIRST) sr_reg <= {sr_reg[WIDTH-2:0], 1'b0};
      else           sr_reg <= {1'b0, sr_reg[WIDTH-1:1]};
    end
  end

  generate
    if (MSB_FIRST) begin : g_head_msb
      assign head = sr_reg[WIDTH-1];
    end else begin : g_head_lsb
      assign head = sr_reg[0];
    end
  endgenerate

  always_comb begin
    out_valid = (state_reg == ST_SHIFT);
    out       = out_valid && head;
    last      = out_valid && (count == LAST_COUNT);
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB/MSB ordering, 8-bit width,
// back-to-back words, stalls, ignored loads and mid-word reset.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;

  // a: WIDTH=4 LSB first, b: WIDTH=4 MSB first, c: WIDTH=8 MSB first
  logic [3:0] in_a = '0;
  logic       lv_a = 1'b0, lr_a, out_a, ov_a, last_a;
  logic [3:0] in_b = '0;
  logic       lv_b = 1'b0, lr_b, out_b, ov_b, last_b;
  logic [7:0] in_c = '0;
  logic       lv_c = 1'b0, lr_c, out_c, ov_c, last_c;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in(in_a), .load_valid(lv_a), .load_ready(lr_a),
    .en(en), .out(out_a), .out_valid(ov_a), .last(last_a)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .load_valid(lv_b), .load_ready(lr_b),
    .en(en), .out(out_b), .out_valid(ov_b), .last(last_b)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst(rst), .in(in_c), .load_valid(lv_c), .load_ready(lr_c),
    .en(en), .out(out_c), .out_valid(ov_c), .last(last_c)
  );

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if ({out_a, ov_a, last_a, lr_a} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_outputs: got {out,ov,last,ready}=%b expected 0000", {out_a, ov_a, last_a, lr_a});
    end
    compared++;
    if ({lr_b, lr_c, ov_b, ov_c} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_other_duts: got %b expected 0000", {lr_b, lr_c, ov_b, ov_c});
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({lr_a, lr_b, lr_c} !== 3'b111) begin
      mismatched++;
      $display("FAIL reset_release_ready: got %b expected 111", {lr_a, lr_b, lr_c});
    end
    $display("tx reset: done");
  endtask

  task automatic test_lsb_first();
    logic exp_out [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    in_a = 4'b1011;
    lv_a = 1'b1;
    @(negedge clk);
    lv_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if ({out_a, ov_a, last_a} !== {exp_out[i], 1'b1, (i == 3)}) begin
        mismatched++;
        $display("FAIL lsb_bit%0d: got {out,ov,last}=%b expected %b", i, {out_a, ov_a, last_a}, {exp_out[i], 1'b1, (i == 3)});
      end
      @(negedge clk);
    end
    compared++;
    if ({out_a, ov_a, lr_a} !== 3'b001) begin
      mismatched++;
      $display("FAIL lsb_idle: got {out,ov,ready}=%b expected 001", {out_a, ov_a, lr_a});
    end
    $display("tx lsb_first word=1011 done");
  endtask

  task automatic test_msb_first();
    logic exp_b [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic exp_c [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    in_b = 4'b1011;
    lv_b = 1'b1;
    @(negedge clk);
    lv_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if ({out_b, ov_b, last_b} !== {exp_b[i], 1'b1, (i == 3)}) begin
        mismatched++;
        $display("FAIL msb4_bit%0d: got {out,ov,last}=%b expected %b", i, {out_b, ov_b, last_b}, {exp_b[i], 1'b1, (i == 3)});
      end
      @(negedge clk);
    end
    compared++;
    if (ov_b !== 1'b0) begin
      mismatched++;
      $display("FAIL msb4_idle: got ov=%b expected 0", ov_b);
    end
    $display("tx msb_first width=4 word=1011 done");

    in_c = 8'hA5;
    lv_c = 1'b1;
    @(negedge clk);
    lv_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      compared++;
      if ({out_c, ov_c, last_c} !== {exp_c[i], 1'b1, (i == 7)}) begin
        mismatched++;
        $display("FAIL msb8_bit%0d: got {out,ov,last}=%b expected %b", i, {out_c, ov_c, last_c}, {exp_c[i], 1'b1, (i == 7)});
      end
      @(negedge clk);
    end
    compared++;
    if (ov_c !== 1'b0) begin
      mismatched++;
      $display("FAIL msb8_idle: got ov=%b expected 0", ov_c);
    end
    $display("tx msb_first width=8 word=a5 done");
  endtask

  task automatic test_back_to_back();
    logic exp_out  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic exp_last [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    in_a = 4'b0001;
    lv_a = 1'b1;
    @(negedge clk);
    in_a = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      compared++;
      if ({out_a, ov_a, last_a} !== {exp_out[i], 1'b1, exp_last[i]}) begin
        mismatched++;
        $display("FAIL b2b_bit%0d: got {out,ov,last}=%b expected %b", i, {out_a, ov_a, last_a}, {exp_out[i], 1'b1, exp_last[i]});
      end
      if (i == 3) begin
        compared++;
        if (lr_a !== 1'b1) begin
          mismatched++;
          $display("FAIL b2b_ready_final: got %b expected 1", lr_a);
        end
      end
      if (i == 7) lv_a = 1'b0;
      @(negedge clk);
    end
    compared++;
    if (ov_a !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_idle: got ov=%b expected 0", ov_a);
    end
    $display("tx back_to_back words=0001,1110 done");
  endtask

  task automatic test_stall();
    logic exp_out  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic en_after [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    in_a = 4'b0110;
    lv_a = 1'b1;
    @(negedge clk);
    lv_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      compared++;
      if ({out_a, ov_a, last_a} !== {exp_out[i], 1'b1, (i == 6)}) begin
        mismatched++;
        $display("FAIL stall_cycle%0d: got {out,ov,last}=%b expected %b", i, {out_a, ov_a, last_a}, {exp_out[i], 1'b1, (i == 6)});
      end
      en = en_after[i];
      @(negedge clk);
    end
    compared++;
    if (ov_a !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_idle: got ov=%b expected 0", ov_a);
    end
    $display("tx stall word=0110 done");
  endtask

  task automatic test_abuse();
    logic exp_out [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    in_a = 4'b1011;
    lv_a = 1'b1;
    @(negedge clk);
    lv_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if ({out_a, ov_a, last_a} !== {exp_out[i], 1'b1, (i == 3)}) begin
        mismatched++;
        $display("FAIL abuse_bit%0d: got {out,ov,last}=%b expected %b", i, {out_a, ov_a, last_a}, {exp_out[i], 1'b1, (i == 3)});
      end
      if (i < 3) begin
        compared++;
        if (lr_a !== 1'b0) begin
          mismatched++;
          $display("FAIL abuse_ready%0d: got %b expected 0", i, lr_a);
        end
        in_a = 4'b0100;
        lv_a = 1'b1;
      end else begin
        lv_a = 1'b0;
      end
      @(negedge clk);
    end
    compared++;
    if (ov_a !== 1'b0) begin
      mismatched++;
      $display("FAIL abuse_idle: got ov=%b expected 0", ov_a);
    end
    $display("tx abuse ignored_load word=1011 done");

    in_a = 4'b1011;
    lv_a = 1'b1;
    @(negedge clk);
    lv_a = 1'b0;
    @(negedge clk);
    compared++;
    if ({out_a, ov_a} !== 2'b11) begin
      mismatched++;
      $display("FAIL abuse_pre_rst: got {out,ov}=%b expected 11", {out_a, ov_a});
    end
    rst = 1'b1;
    #1;
    compared++;
    if ({out_a, ov_a, last_a, lr_a} !== 4'b0000) begin
      mismatched++;
      $display("FAIL abuse_async_rst: got {out,ov,last,ready}=%b expected 0000", {out_a, ov_a, last_a, lr_a});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({out_a, ov_a, last_a, lr_a} !== 4'b0001) begin
      mismatched++;
      $display("FAIL abuse_post_rst: got {out,ov,last,ready}=%b expected 0001", {out_a, ov_a, last_a, lr_a});
    end
    @(negedge clk);
    compared++;
    if (ov_a !== 1'b0) begin
      mismatched++;
      $display("FAIL abuse_no_resume: got ov=%b expected 0", ov_a);
    end
    $display("tx abuse mid_word_reset done");
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_stall();
    test_abuse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
